// File: rtl/sync_mux_arbiter_if.sv
// Producer handshakes plus the x1/x2/addr selection bus that feeds SyncMux.
// The master modport is the arbiter's view; slave is the environment's view.
interface sync_mux_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             in0_valid;
    logic             in0_ready;
    logic [WIDTH-1:0] in0_data;
    logic             in1_valid;
    logic             in1_ready;
    logic [WIDTH-1:0] in1_data;
    logic [WIDTH-1:0] x1;
    logic [WIDTH-1:0] x2;
    logic             addr;
    logic             sel_valid;
    logic             sel_ready;

    modport master (
        input  in0_valid, in0_data, in1_valid, in1_data, sel_ready,
        output in0_ready, in1_ready, x1, x2, addr, sel_valid
    );

    modport slave (
        output in0_valid, in0_data, in1_valid, in1_data, sel_ready,
        input  in0_ready, in1_ready, x1, x2, addr, sel_valid
    );
endinterface

// File: rtl/sync_mux_arbiter.sv
// Two-channel round-robin arbiter with bounded bursts, registering the winning
// word onto x1/x2 and the matching addr for SyncMux, with downstream backpressure.
module sync_mux_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                clr,
    sync_mux_arbiter_if.master  bus
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    burst_cnt_q, burst_cnt_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] x1_q, x1_d;
    logic [WIDTH-1:0] x2_q, x2_d;
    logic             addr_q, addr_d;
    logic             sel_valid_q, sel_valid_d;

    logic             in0_ready_s, in1_ready_s;
    logic             xfer0_s, xfer1_s, xfer_s;
    logic             cur_valid_s, oth_valid_s;
    state_t           other_s;
    logic [CW-1:0]    cnt_inc_s;

    // Readies: granted channel may load whenever the selection slot is free or draining.
    always_comb begin
        in0_ready_s = !clr && (state_q == GNT0) && (!sel_valid_q || bus.sel_ready);
        in1_ready_s = !clr && (state_q == GNT1) && (!sel_valid_q || bus.sel_ready);
        xfer0_s     = bus.in0_valid && in0_ready_s;
        xfer1_s     = bus.in1_valid && in1_ready_s;
        xfer_s      = xfer0_s || xfer1_s;
    end

    // Next-state, burst counter and round-robin pointer.
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        last_d      = last_q;
        cur_valid_s = (state_q == GNT1) ? bus.in1_valid : bus.in0_valid;
        oth_valid_s = (state_q == GNT1) ? bus.in0_valid : bus.in1_valid;
        other_s     = (state_q == GNT1) ? GNT0 : GNT1;
        cnt_inc_s   = burst_cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                burst_cnt_d = '0;
                if (bus.in0_valid && (!bus.in1_valid || last_q)) begin
                    state_d = GNT0;
                end else if (bus.in1_valid) begin
                    state_d = GNT1;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT0, GNT1: begin
                if (xfer_s) begin
                    burst_cnt_d = cnt_inc_s;
                    last_d      = (state_q == GNT1);
                end else begin
                    burst_cnt_d = burst_cnt_q;
                end
                // A full burst always clears the counter, even when nobody else waits.
                if (xfer_s && (cnt_inc_s == MAX_CNT)) begin
                    burst_cnt_d = '0;
                    state_d     = oth_valid_s ? other_s : state_q;
                end else if (!cur_valid_s) begin
                    burst_cnt_d = '0;
                    state_d     = oth_valid_s ? other_s : IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    // Selection datapath: load on transfer, otherwise hold until consumed.
    always_comb begin
        x1_d        = x1_q;
        x2_d        = x2_q;
        addr_d      = addr_q;
        sel_valid_d = sel_valid_q;
        if (xfer0_s) begin
            x1_d        = bus.in0_data;
            addr_d      = 1'b0;
            sel_valid_d = 1'b1;
        end else if (xfer1_s) begin
            x2_d        = bus.in1_data;
            addr_d      = 1'b1;
            sel_valid_d = 1'b1;
        end else if (bus.sel_ready) begin
            sel_valid_d = 1'b0;
        end else begin
            sel_valid_d = sel_valid_q;
        end
    end

    // FSM state register; last resets to 1 so channel 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
            last_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            last_q      <= last_d;
        end
    end

    // Selection registers driving SyncMux.
    always_ff @(posedge clk) begin
        if (clr) begin
            x1_q        <= '0;
            x2_q        <= '0;
            addr_q      <= 1'b0;
            sel_valid_q <= 1'b0;
        end else begin
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            addr_q      <= addr_d;
            sel_valid_q <= sel_valid_d;
        end
    end

    assign bus.in0_ready = in0_ready_s;
    assign bus.in1_ready = in1_ready_s;
    assign bus.x1        = x1_q;
    assign bus.x2        = x2_q;
    assign bus.addr      = addr_q;
    assign bus.sel_valid = sel_valid_q;
endmodule

// File: tb/tb_sync_mux_arbiter.sv
// Bench for sync_mux_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level reference model and an ordering scoreboard.
module tb_sync_mux_arbiter;
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;

    logic clk = 1'b0;
    logic clr;

    sync_mux_arbiter_if #(.WIDTH(WIDTH)) bus ();

    sync_mux_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: owner -1 = nobody granted, else channel index.
    int               m_owner;
    int               m_run;
    int               m_last;
    logic [WIDTH-1:0] m_x1, m_x2;
    logic             m_addr, m_sv;
    logic [WIDTH:0]   sb_q [$];

    function automatic logic m_rdy(int k);
        return !clr && (m_owner == k) && (!m_sv || bus.sel_ready);
    endfunction

    task automatic model_edge();
        logic [1:0] v;
        logic acc;
        int k, o;
        v = {bus.in1_valid, bus.in0_valid};
        if (clr) begin
            m_owner = -1; m_run = 0; m_last = 1;
            m_x1 = '0; m_x2 = '0; m_addr = 1'b0; m_sv = 1'b0;
            sb_q.delete();
            return;
        end
        acc = 1'b0;
        if (m_owner >= 0) acc = v[m_owner] && m_rdy(m_owner);
        if (acc) begin
            if (m_owner == 0) begin
                m_x1 = bus.in0_data; m_addr = 1'b0; sb_q.push_back({1'b0, bus.in0_data});
            end else begin
                m_x2 = bus.in1_data; m_addr = 1'b1; sb_q.push_back({1'b1, bus.in1_data});
            end
            m_sv = 1'b1;
        end else if (bus.sel_ready) begin
            m_sv = 1'b0;
        end
        if (m_owner < 0) begin
            m_run = 0;
            if (v[0] && (!v[1] || m_last == 1)) m_owner = 0;
            else if (v[1]) m_owner = 1;
        end else begin
            k = m_owner;
            o = 1 - k;
            if (acc) begin m_run++; m_last = k; end
            if (acc && m_run == MAX_BURST) begin
                m_run = 0;
                if (v[o]) m_owner = o;
            end else if (!v[k]) begin
                m_run = 0;
                m_owner = v[o] ? o : -1;
            end
        end
    endtask

    task automatic drv(input logic c, input logic v0, input logic [WIDTH-1:0] d0,
                       input logic v1, input logic [WIDTH-1:0] d1, input logic sr);
        clr = c; bus.in0_valid = v0; bus.in0_data = d0;
        bus.in1_valid = v1; bus.in1_data = d1; bus.sel_ready = sr;
        #1;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drv(1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_chk++;
            if ({bus.in0_ready, bus.in1_ready, bus.x1, bus.x2, bus.addr, bus.sel_valid} !== 20'h0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc %0d: got x1=%h x2=%h addr=%b sv=%b rdy=%b%b, expected all 0",
                         i, bus.x1, bus.x2, bus.addr, bus.sel_valid, bus.in0_ready, bus.in1_ready);
            end
        end
        drv(1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1);
        n_chk++;
        if ({bus.in0_ready, bus.in1_ready} !== 2'b00) begin
            n_fail++; $display("FAIL reset_idle_ready: got %b%b expected 00", bus.in0_ready, bus.in1_ready);
        end
        tick();
        n_chk++;
        if ({bus.in0_ready, bus.in1_ready} !== 2'b10) begin
            n_fail++; $display("FAIL reset_first_grant: got %b%b expected 10", bus.in0_ready, bus.in1_ready);
        end
        tick();
        n_chk++;
        if ({bus.x1, bus.addr, bus.sel_valid} !== {8'h11, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL reset_first_word: got x1=%h addr=%b sv=%b expected 11 0 1",
                               bus.x1, bus.addr, bus.sel_valid);
        end
        drv(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        tick();
    endtask

    task automatic test_single_ch1();
        drv(1'b0, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b1);
        tick();
        n_chk++;
        if ({bus.in0_ready, bus.in1_ready} !== 2'b01) begin
            n_fail++; $display("FAIL single_grant: got %b%b expected 01", bus.in0_ready, bus.in1_ready);
        end
        tick();
        drv(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        n_chk++;
        if ({bus.x1, bus.x2, bus.addr, bus.sel_valid} !== {8'h11, 8'hA5, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL single_word: got x1=%h x2=%h addr=%b sv=%b expected 11 a5 1 1",
                               bus.x1, bus.x2, bus.addr, bus.sel_valid);
        end
        tick();
        n_chk++;
        if (bus.sel_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_drop: got sv=%b expected 0", bus.sel_valid);
        end
        tick();
    endtask

    task automatic test_burst();
        logic [WIDTH-1:0] d0, d1, e0, e1;
        logic a0, a1, ea;
        int nc;
        d0 = 8'h00; d1 = 8'h80; e0 = 8'h00; e1 = 8'h80; nc = 0;
        for (int i = 0; i < 40; i++) begin
            drv(1'b0, 1'b1, d0, 1'b1, d1, 1'b1);
            n_chk++;
            if ({bus.in0_ready, bus.in1_ready} !== {m_rdy(0), m_rdy(1)}) begin
                n_fail++; $display("FAIL burst_ready cyc %0d: got %b%b expected %b%b",
                                   i, bus.in0_ready, bus.in1_ready, m_rdy(0), m_rdy(1));
            end
            if (m_sv) begin
                ea = ((nc / MAX_BURST) % 2) != 0;
                n_chk++;
                if ({bus.addr, bus.addr ? bus.x2 : bus.x1} !== {ea, ea ? e1 : e0}) begin
                    n_fail++; $display("FAIL burst_order word %0d: got addr=%b data=%h expected addr=%b data=%h",
                                       nc, bus.addr, bus.addr ? bus.x2 : bus.x1, ea, ea ? e1 : e0);
                end
                if (ea) e1++; else e0++;
                nc++;
            end
            a0 = m_rdy(0);
            a1 = m_rdy(1);
            tick();
            n_chk++;
            if ({bus.x1, bus.x2, bus.addr, bus.sel_valid} !== {m_x1, m_x2, m_addr, m_sv}) begin
                n_fail++; $display("FAIL burst_out cyc %0d: got %h %h %b %b expected %h %h %b %b",
                                   i, bus.x1, bus.x2, bus.addr, bus.sel_valid, m_x1, m_x2, m_addr, m_sv);
            end
            if (a0) d0++;
            if (a1) d1++;
        end
        drv(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] d0;
        logic a0;
        int acc;
        d0 = 8'h3E; acc = 0;
        for (int i = 0; i < 20 && acc < 4; i++) begin
            drv(1'b0, 1'b1, d0, 1'b0, 8'h00, 1'b1);
            a0 = m_rdy(0);
            tick();
            if (a0) begin d0++; acc++; end
        end
        n_chk++;
        if (acc != 4) begin
            n_fail++; $display("FAIL bp_stream: got %0d accepted words, expected 4", acc);
        end
        for (int i = 0; i < 3; i++) begin
            drv(1'b0, 1'b1, 8'h42, 1'b0, 8'h00, 1'b0);
            n_chk++;
            if ({bus.in0_ready, bus.x1, bus.addr, bus.sel_valid} !== {1'b0, 8'h41, 1'b0, 1'b1}) begin
                n_fail++; $display("FAIL bp_hold cyc %0d: got rdy=%b x1=%h addr=%b sv=%b expected 0 41 0 1",
                                   i, bus.in0_ready, bus.x1, bus.addr, bus.sel_valid);
            end
            tick();
        end
        drv(1'b0, 1'b1, 8'h42, 1'b0, 8'h00, 1'b1);
        n_chk++;
        if (bus.in0_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release_ready: got %b expected 1", bus.in0_ready);
        end
        tick();
        n_chk++;
        if ({bus.x1, bus.addr, bus.sel_valid} !== {8'h42, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL bp_release_word: got x1=%h addr=%b sv=%b expected 42 0 1",
                               bus.x1, bus.addr, bus.sel_valid);
        end
        drv(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        tick();
        tick();
    endtask

    task automatic test_tiebreak();
        drv(1'b0, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b1);
        tick();
        tick();
        drv(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        tick();
        tick();
        drv(1'b0, 1'b1, 8'hC3, 1'b1, 8'h3C, 1'b1);
        tick();
        n_chk++;
        if ({bus.in0_ready, bus.in1_ready} !== 2'b10) begin
            n_fail++; $display("FAIL tie_grant: got %b%b expected 10", bus.in0_ready, bus.in1_ready);
        end
        tick();
        n_chk++;
        if ({bus.x1, bus.x2, bus.addr, bus.sel_valid} !== {8'hC3, 8'h5A, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL tie_word: got x1=%h x2=%h addr=%b sv=%b expected c3 5a 0 1",
                               bus.x1, bus.x2, bus.addr, bus.sel_valid);
        end
        drv(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        tick();
        tick();
    endtask

    task automatic test_clr_mid();
        drv(1'b0, 1'b1, 8'h21, 1'b0, 8'h00, 1'b1);
        tick();
        tick();
        drv(1'b0, 1'b1, 8'h22, 1'b0, 8'h00, 1'b1);
        tick();
        drv(1'b0, 1'b1, 8'h23, 1'b0, 8'h00, 1'b0);
        n_chk++;
        if ({bus.in0_ready, bus.x1, bus.sel_valid} !== {1'b0, 8'h22, 1'b1}) begin
            n_fail++; $display("FAIL clr_setup: got rdy=%b x1=%h sv=%b expected 0 22 1",
                               bus.in0_ready, bus.x1, bus.sel_valid);
        end
        drv(1'b1, 1'b1, 8'h23, 1'b1, 8'h77, 1'b0);
        tick();
        n_chk++;
        if ({bus.in0_ready, bus.in1_ready, bus.x1, bus.x2, bus.addr, bus.sel_valid} !== 20'h0) begin
            n_fail++; $display("FAIL clr_mid: got x1=%h x2=%h addr=%b sv=%b rdy=%b%b expected all 0",
                               bus.x1, bus.x2, bus.addr, bus.sel_valid, bus.in0_ready, bus.in1_ready);
        end
        drv(1'b0, 1'b1, 8'h23, 1'b1, 8'h77, 1'b1);
        tick();
        n_chk++;
        if ({bus.in0_ready, bus.in1_ready} !== 2'b10) begin
            n_fail++; $display("FAIL clr_regrant: got %b%b expected 10", bus.in0_ready, bus.in1_ready);
        end
        drv(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        tick();
        tick();
    endtask

    task automatic test_random();
        logic v0, v1, c, sr, a0, a1;
        logic [WIDTH-1:0] d0, d1;
        v0 = 1'b0; v1 = 1'b0; d0 = 8'h00; d1 = 8'h00;
        for (int i = 0; i < 1500; i++) begin
            c  = ($urandom_range(99) == 0);
            sr = ($urandom_range(3) != 0);
            if (!v0) begin v0 = ($urandom_range(2) != 0); d0 = 8'($urandom); end
            if (!v1) begin v1 = ($urandom_range(2) != 0); d1 = 8'($urandom); end
            drv(c, v0, d0, v1, d1, sr);
            n_chk++;
            if ({bus.in0_ready, bus.in1_ready} !== {m_rdy(0), m_rdy(1)}) begin
                n_fail++; $display("FAIL rand_ready cyc %0d: got %b%b expected %b%b",
                                   i, bus.in0_ready, bus.in1_ready, m_rdy(0), m_rdy(1));
            end
            if (m_sv && sr) begin
                n_chk++;
                if (sb_q.size() == 0 || {bus.addr, bus.addr ? bus.x2 : bus.x1} !== sb_q[0]) begin
                    n_fail++; $display("FAIL rand_scoreboard cyc %0d: got %h expected %h (queue %0d)",
                                       i, {bus.addr, bus.addr ? bus.x2 : bus.x1},
                                       (sb_q.size() != 0) ? sb_q[0] : 9'h0, sb_q.size());
                end
                if (sb_q.size() != 0) void'(sb_q.pop_front());
            end
            a0 = v0 && m_rdy(0);
            a1 = v1 && m_rdy(1);
            tick();
            n_chk++;
            if ({bus.x1, bus.x2, bus.addr, bus.sel_valid} !== {m_x1, m_x2, m_addr, m_sv}) begin
                n_fail++; $display("FAIL rand_out cyc %0d: got %h %h %b %b expected %h %h %b %b",
                                   i, bus.x1, bus.x2, bus.addr, bus.sel_valid, m_x1, m_x2, m_addr, m_sv);
            end
            if (a0 || c) v0 = 1'b0;
            if (a1 || c) v1 = 1'b0;
        end
    endtask

    initial begin
        m_owner = -1; m_run = 0; m_last = 1;
        m_x1 = '0; m_x2 = '0; m_addr = 1'b0; m_sv = 1'b0;
        test_reset();
        test_single_ch1();
        test_burst();
        test_backpressure();
        test_tiebreak();
        test_clr_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 ns, expected completion");
        $fatal(1, "time limit reached");
    end
endmodule
